// File: rtl/sm_run_ctrl_pkg.sv
// Shared op codes and FSM state encodings for the run controller.
package sm_run_ctrl_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    // Command op codes
    localparam op_t OP_RUN  = 2'b00;
    localparam op_t OP_HALT = 2'b01;
    localparam op_t OP_STEP = 2'b10;
    localparam op_t OP_DUMP = 2'b11;

    // FSM state encodings
    localparam state_t ST_HALT = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_STEP = 2'b10;
    localparam state_t ST_DUMP = 2'b11;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WORD_W     = 32;

endpackage

// File: rtl/sm_run_ctrl_if.sv
// Host-side command handshake and register-dump stream of the run controller.
interface sm_run_ctrl_if #(
    parameter int unsigned STEP_W = 16
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [STEP_W-1:0]   cmd_arg;
    logic                cmd_err;
    logic                dump_valid;
    logic [4:0]          dump_addr;
    logic [31:0]         dump_data;

    // Host issuing commands and consuming the dump stream
    modport master (
        output cmd_valid, cmd_op, cmd_arg,
        input  cmd_ready, cmd_err, dump_valid, dump_addr, dump_data
    );

    // Controller side
    modport slave (
        input  cmd_valid, cmd_op, cmd_arg,
        output cmd_ready, cmd_err, dump_valid, dump_addr, dump_data
    );
endinterface

// File: rtl/sm_run_step_cnt.sv
// Loadable down-counter for STEP; a load of 0 is treated as 1.
module sm_run_step_cnt #(
    parameter int unsigned STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              en,
    output logic [STEP_W-1:0] cnt,
    output logic              is_one
);
    logic [STEP_W-1:0] cnt_q;

    // Load has priority; decrement only while enabled and non-zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (load_val == '0) ? STEP_W'(1) : load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - STEP_W'(1);
        end
    end

    assign cnt    = cnt_q;
    assign is_one = (cnt_q == STEP_W'(1));

endmodule

// File: rtl/sm_run_ctrl.sv
// Debug run controller: gates the CPU clock for RUN/STEP, stops on breakpoints,
// and streams the register file out on DUMP.
module sm_run_ctrl
    import sm_run_ctrl_pkg::*;
#(
    parameter int unsigned STEP_W   = 16,
    parameter int unsigned RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    sm_run_ctrl_if.slave cmd,
    input  logic        bp_en,
    input  logic [31:0] bp_pc,
    output logic        cpu_clk_en,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        halted,
    output logic        bp_hit
);
    localparam logic [4:0] LAST_IDX = 5'(RF_DEPTH - 1);

    state_t      state_q, state_d;
    logic        skip_q, skip_d;
    logic        bp_hit_q, bp_hit_d;
    logic        cmd_err_q, cmd_err_d;
    logic [4:0]  dump_idx_q, dump_idx_d;

    logic              cmd_ready;
    logic              accept;
    logic              bp_fire;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_is_one;
    logic [STEP_W-1:0] cnt_val;
    logic              dump_valid;

    sm_run_step_cnt #(
        .STEP_W (STEP_W)
    ) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cmd.cmd_arg),
        .en       (cnt_en),
        .cnt      (cnt_val),
        .is_one   (cnt_is_one)
    );

    // Commands are only taken in HALT/RUN and never while reset is held
    assign cmd_ready = !rst && ((state_q == ST_HALT) || (state_q == ST_RUN));
    assign accept    = cmd.cmd_valid && cmd_ready;
    // reg_addr is 0 in RUN, so reg_data is the live PC here
    assign bp_fire   = bp_en && (reg_data == bp_pc) && !skip_q;

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        bp_hit_d   = bp_hit_q;
        cmd_err_d  = 1'b0;
        dump_idx_d = dump_idx_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cpu_clk_en = 1'b0;
        reg_addr   = '0;
        dump_valid = 1'b0;

        case (state_q)
            ST_HALT: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_RUN: begin
                            state_d  = ST_RUN;
                            skip_d   = 1'b1;
                            bp_hit_d = 1'b0;
                        end
                        OP_STEP: begin
                            state_d  = ST_STEP;
                            cnt_load = 1'b1;
                            bp_hit_d = 1'b0;
                        end
                        OP_DUMP: begin
                            state_d    = ST_DUMP;
                            dump_idx_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // First RUN cycle after resume skips the compare so a
                // breakpoint PC can be stepped past
                skip_d     = 1'b0;
                cpu_clk_en = 1'b1;
                if (bp_fire) begin
                    cpu_clk_en = 1'b0;
                    state_d    = ST_HALT;
                    bp_hit_d   = 1'b1;
                end
                if (accept) begin
                    if (cmd.cmd_op == OP_HALT) begin
                        cpu_clk_en = 1'b0;
                        state_d    = ST_HALT;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                cpu_clk_en = 1'b1;
                cnt_en     = 1'b1;
                if (cnt_is_one) begin
                    state_d = ST_HALT;
                end
            end
            ST_DUMP: begin
                reg_addr   = dump_idx_q;
                dump_valid = 1'b1;
                if (dump_idx_q == LAST_IDX) begin
                    state_d    = ST_HALT;
                    dump_idx_d = '0;
                end else begin
                    dump_idx_d = dump_idx_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HALT;
            skip_q     <= 1'b0;
            bp_hit_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            dump_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            bp_hit_q   <= bp_hit_d;
            cmd_err_q  <= cmd_err_d;
            dump_idx_q <= dump_idx_d;
        end
    end

    assign halted         = (state_q == ST_HALT);
    assign bp_hit         = bp_hit_q;
    assign cmd.cmd_ready  = cmd_ready;
    assign cmd.cmd_err    = cmd_err_q;
    assign cmd.dump_valid = dump_valid;
    assign cmd.dump_addr  = reg_addr;
    assign cmd.dump_data  = reg_data;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl with a tiny CPU/register-file model.
module tb_sm_run_ctrl;
    import sm_run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bp_en;
    logic [31:0] bp_pc;
    logic        cpu_clk_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        halted;
    logic        bp_hit;

    int n_checks = 0;
    int n_fail   = 0;

    sm_run_ctrl_if #(.STEP_W(16)) bus ();

    sm_run_ctrl #(
        .STEP_W   (16),
        .RF_DEPTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (bus),
        .bp_en      (bp_en),
        .bp_pc      (bp_pc),
        .cpu_clk_en (cpu_clk_en),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .halted     (halted),
        .bp_hit     (bp_hit)
    );

    always #5 clk = ~clk;

    // CPU model: PC advances on every enabled clock
    logic [31:0] pc = 32'd0;
    always @(posedge clk) if (cpu_clk_en) pc <= pc + 32'd1;

    function automatic logic [31:0] rf_val(input logic [4:0] a, input logic [31:0] cur_pc);
        if (a == 5'd0) return cur_pc;
        if (a == 5'd2) return 32'h0000_1234;
        return 32'h0000_A000 + {27'd0, a};
    endfunction

    always_comb reg_data = rf_val(reg_addr, pc);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        int          n;
        logic [31:0] p;
        int          beats, ae, de, re;
        logic [31:0] d2;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_RUN;
        bus.cmd_arg   = '0;
        bp_en         = 1'b0;
        bp_pc         = '0;

        // Reset values and no acceptance under reset
        repeat (2) next_cyc();
        check_eq("rst_halted", halted, 1'b1);
        check_eq("rst_clk_en", cpu_clk_en, 1'b0);
        check_eq("rst_reg_addr", reg_addr, 5'd0);
        check_eq("rst_bp_hit", bp_hit, 1'b0);
        check_eq("rst_cmd_err", bus.cmd_err, 1'b0);
        check_eq("rst_dump_valid", bus.dump_valid, 1'b0);
        bus.cmd_valid = 1'b1;
        #1;
        check_eq("rst_cmd_ready", bus.cmd_ready, 1'b0);
        next_cyc();
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        next_cyc();
        check_eq("rst_no_accept", halted, 1'b1);

        // Breakpoint at PC 5
        bp_en = 1'b1;
        bp_pc = 32'd5;
        issue(OP_RUN, 16'd0);
        n = 0;
        for (int i = 0; i < 20 && cpu_clk_en; i++) begin
            n++;
            next_cyc();
        end
        check_eq("bp_run_cycles", n, 5);
        check_eq("bp_stop_pc", pc, 32'd5);
        check_eq("bp_clk_en_drop", cpu_clk_en, 1'b0);
        next_cyc();
        check_eq("bp_halted", halted, 1'b1);
        check_eq("bp_hit_set", bp_hit, 1'b1);
        next_cyc();
        check_eq("bp_pc_hold", pc, 32'd5);

        // Resume past the breakpoint, then HALT mid-run
        issue(OP_RUN, 16'd0);
        check_eq("resume_clk_en", cpu_clk_en, 1'b1);
        check_eq("resume_bp_clr", bp_hit, 1'b0);
        next_cyc();
        check_eq("resume_pc6", pc, 32'd6);
        check_eq("resume_running", cpu_clk_en, 1'b1);
        repeat (2) next_cyc();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_HALT;
        #1;
        check_eq("halt_same_cycle", cpu_clk_en, 1'b0);
        p = pc;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        check_eq("halt_halted", halted, 1'b1);
        check_eq("halt_pc_hold", pc, p);
        check_eq("halt_bp_unchanged", bp_hit, 1'b0);

        // STEP while running is rejected
        bp_en = 1'b0;
        issue(OP_RUN, 16'd0);
        next_cyc();
        p = pc;
        issue(OP_STEP, 16'd3);
        check_eq("err_pulse", bus.cmd_err, 1'b1);
        check_eq("err_still_run", cpu_clk_en, 1'b1);
        check_eq("err_not_halted", halted, 1'b0);
        next_cyc();
        check_eq("err_one_cycle", bus.cmd_err, 1'b0);
        check_eq("err_pc_adv", pc, p + 32'd2);
        issue(OP_HALT, 16'd0);
        check_eq("err_halt", halted, 1'b1);

        // STEP 3 and STEP 0
        p = pc;
        issue(OP_STEP, 16'd3);
        check_eq("step_cmd_ready", bus.cmd_ready, 1'b0);
        n = 0;
        for (int i = 0; i < 10 && !halted; i++) begin
            if (cpu_clk_en) n++;
            next_cyc();
        end
        check_eq("step3_cycles", n, 3);
        check_eq("step3_pc", pc, p + 32'd3);
        check_eq("step3_halted", halted, 1'b1);
        p = pc;
        issue(OP_STEP, 16'd0);
        n = 0;
        for (int i = 0; i < 10 && !halted; i++) begin
            if (cpu_clk_en) n++;
            next_cyc();
        end
        check_eq("step0_cycles", n, 1);
        check_eq("step0_pc", pc, p + 32'd1);

        // Full register dump
        issue(OP_DUMP, 16'd0);
        beats = 0; ae = 0; de = 0; re = 0; d2 = '0;
        for (int i = 0; i < 40 && bus.dump_valid; i++) begin
            if (bus.dump_addr !== 5'(beats)) ae++;
            if (bus.dump_data !== rf_val(5'(beats), pc)) de++;
            if (bus.cmd_ready !== 1'b0 || cpu_clk_en !== 1'b0) re++;
            if (beats == 2) d2 = bus.dump_data;
            beats++;
            next_cyc();
        end
        check_eq("dump_beats", beats, 32);
        check_eq("dump_addr_errs", ae, 0);
        check_eq("dump_data_errs", de, 0);
        check_eq("dump_ready_errs", re, 0);
        check_eq("dump_beat2", d2, 32'h0000_1234);
        check_eq("dump_end_halted", halted, 1'b1);
        check_eq("dump_end_addr", reg_addr, 5'd0);

        // Reset in the middle of a dump
        issue(OP_DUMP, 16'd0);
        repeat (10) next_cyc();
        check_eq("mid_dump_addr", bus.dump_addr, 5'd10);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_reg_addr", reg_addr, 5'd0);
        check_eq("mid_rst_dump_valid", bus.dump_valid, 1'b0);
        check_eq("mid_rst_clk_en", cpu_clk_en, 1'b0);
        check_eq("mid_rst_halted", halted, 1'b1);
        next_cyc();
        rst = 1'b0;
        next_cyc();
        issue(OP_DUMP, 16'd0);
        check_eq("redump_valid", bus.dump_valid, 1'b1);
        check_eq("redump_addr0", bus.dump_addr, 5'd0);
        check_eq("redump_data0", bus.dump_data, pc);
        for (int i = 0; i < 40 && !halted; i++) next_cyc();
        check_eq("redump_done", halted, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
